decode_stage_controller: RTL and testbench

//  Global sequencer directly upstream of the processing_unit array. Drives global_stage to every PE.

---
 rtl/decode_stage_controller.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_controller.sv
// Global decode sequencer: loads syndrome contexts into PE memory, then
// restores each one and drives GROW/MERGE until no odd cluster remains.
module decode_stage_controller #(
    parameter int NUM_CONTEXTS    = 2,
    parameter int MERGE_QUIET     = 3,
    parameter int MEM_READ_CYCLES = 3,
    parameter int PEEL_CYCLES     = 2,
    parameter int MAX_ITER        = 63,
    parameter int STAGE_WIDTH     = 3,
    parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE                  = 3'd0,
    parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_PREPARING = 3'd1,
    parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING   = 3'd2,
    parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM          = 3'd3,
    parameter logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM         = 3'd4,
    parameter logic [STAGE_WIDTH-1:0] STAGE_GROW                  = 3'd5,
    parameter logic [STAGE_WIDTH-1:0] STAGE_MERGE                 = 3'd6,
    parameter logic [STAGE_WIDTH-1:0] STAGE_PEELING               = 3'd7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    output logic                   start_ready,
    output logic                   meas_load_ready,
    input  logic                   busy_any,
    input  logic                   odd_any,
    output logic [STAGE_WIDTH-1:0] global_stage,
    output logic [3:0]             context_id,
    output logic [5:0]             iter_count,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   overflow_err
);

    localparam int CNT_A   = (MEM_READ_CYCLES > PEEL_CYCLES) ? MEM_READ_CYCLES : PEEL_CYCLES;
    localparam int CNT_LIM = (CNT_A > 2) ? CNT_A : 2;
    localparam int CNT_W   = $clog2(CNT_LIM + 1);
    localparam int QW      = $clog2(MERGE_QUIET + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREP, S_LOAD, S_SAVE_L, S_RESTORE,
        S_GROW, S_MERGE, S_PEEL, S_RESULT, S_SAVE_D
    } state_t;

    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [QW-1:0]          r_quiet, w_quiet_next, w_quiet_inc;
    logic [3:0]             r_ctx, w_ctx_next;
    logic [5:0]             r_iter, w_iter_next;
    logic                   r_ovf, w_ovf_next;
    logic                   r_start_ready, r_load_ready, r_result_valid;
    logic [STAGE_WIDTH-1:0] r_stage, w_stage;
    logic                   w_last_ctx;

    assign w_last_ctx  = (r_ctx >= 4'(NUM_CONTEXTS - 1));
    assign w_quiet_inc = busy_any ? '0 : r_quiet + QW'(1);

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_quiet_next = r_quiet;
        w_ctx_next   = r_ctx;
        w_iter_next  = r_iter;
        w_ovf_next   = r_ovf;
        unique case (r_state)
            S_IDLE: begin
                if (start_valid && r_start_ready) begin
                    w_next     = S_PREP;
                    w_ctx_next = '0;
                    w_ovf_next = 1'b0;
                end
            end
            S_PREP: w_next = S_LOAD;
            S_LOAD: w_next = S_SAVE_L;
            S_SAVE_L, S_SAVE_D: begin
                if (!w_last_ctx) begin
                    w_ctx_next = r_ctx + 4'd1;
                    w_next     = (r_state == S_SAVE_L) ? S_LOAD : S_RESTORE;
                end else begin
                    w_ctx_next = '0;
                    w_next     = (r_state == S_SAVE_L) ? S_RESTORE : S_IDLE;
                end
                w_cnt_next  = '0;
                w_iter_next = '0;
            end
            S_RESTORE: begin
                if (r_cnt == CNT_W'(MEM_READ_CYCLES - 1)) begin
                    w_next     = S_GROW;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_GROW: begin
                w_next       = S_MERGE;
                w_cnt_next   = '0;
                w_quiet_next = '0;
                if (r_iter != 6'(MAX_ITER))
                    w_iter_next = r_iter + 6'd1;
            end
            S_MERGE: begin
                // busy_any lags the stage change through the PE pipeline
                if (r_cnt < CNT_W'(2)) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end else begin
                    w_quiet_next = w_quiet_inc;
                    if (w_quiet_inc == QW'(MERGE_QUIET)) begin
                        w_cnt_next = '0;
                        if (!odd_any) begin
                            w_next = S_PEEL;
                        end else if (r_iter < 6'(MAX_ITER)) begin
                            w_next = S_GROW;
                        end else begin
                            w_ovf_next = 1'b1;
                            w_next     = S_PEEL;
                        end
                    end
                end
            end
            S_PEEL: begin
                if (r_cnt == CNT_W'(PEEL_CYCLES - 1)) begin
                    w_next     = S_RESULT;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_RESULT: begin
                if (r_result_valid && result_ready)
                    w_next = S_SAVE_D;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_stage = STAGE_IDLE;
        unique case (w_next)
            S_IDLE:              w_stage = STAGE_IDLE;
            S_PREP:              w_stage = STAGE_MEASUREMENT_PREPARING;
            S_LOAD:              w_stage = STAGE_MEASUREMENT_LOADING;
            S_SAVE_L, S_SAVE_D:  w_stage = STAGE_WRITE_TO_MEM;
            S_RESTORE:           w_stage = STAGE_READ_FROM_MEM;
            S_GROW:              w_stage = STAGE_GROW;
            S_MERGE:             w_stage = STAGE_MERGE;
            S_PEEL, S_RESULT:    w_stage = STAGE_PEELING;
            default:             w_stage = STAGE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_quiet        <= '0;
            r_ctx          <= '0;
            r_iter         <= '0;
            r_ovf          <= 1'b0;
            r_stage        <= STAGE_IDLE;
            r_start_ready  <= 1'b1;
            r_load_ready   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_quiet        <= w_quiet_next;
            r_ctx          <= w_ctx_next;
            r_iter         <= w_iter_next;
            r_ovf          <= w_ovf_next;
            r_stage        <= w_stage;
            r_start_ready  <= (w_next == S_IDLE);
            r_load_ready   <= (w_next == S_LOAD);
            r_result_valid <= (w_next == S_RESULT);
        end
    end

    assign global_stage    = r_stage;
    assign start_ready     = r_start_ready;
    assign meas_load_ready = r_load_ready;
    assign result_valid    = r_result_valid;
    assign context_id      = r_ctx;
    assign iter_count      = r_iter;
    assign overflow_err    = r_ovf;

endmodule

// File: tb/tb_decode_stage_controller.sv
// Directed bench for decode_stage_controller: load/decode sequencing,
// merge convergence, iteration overflow, result back-pressure and reset.
module tb_decode_stage_controller;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PREP  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_GROW  = 3'd5;
    localparam logic [2:0] ST_MERGE = 3'd6;
    localparam logic [2:0] ST_PEEL  = 3'd7;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic       meas_load_ready;
    logic       busy_any;
    logic       odd_any;
    logic [2:0] global_stage;
    logic [3:0] context_id;
    logic [5:0] iter_count;
    logic       result_valid;
    logic       result_ready;
    logic       overflow_err;

    int errors = 0;
    int checks = 0;

    decode_stage_controller #(.MAX_ITER(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .meas_load_ready (meas_load_ready),
        .busy_any        (busy_any),
        .odd_any         (odd_any),
        .global_stage    (global_stage),
        .context_id      (context_id),
        .iter_count      (iter_count),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] stg,
                              input logic sr, input logic lr,
                              input logic rv, input logic [3:0] ctx);
        chk({tag, ".stage"}, 32'(global_stage), 32'(stg));
        chk({tag, ".start_ready"}, 32'(start_ready), 32'(sr));
        chk({tag, ".load_ready"}, 32'(meas_load_ready), 32'(lr));
        chk({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
        chk({tag, ".ctx"}, 32'(context_id), 32'(ctx));
    endtask

    initial begin
        int grows;
        int n;
        reset        = 1'b0;
        start_valid  = 1'b0;
        busy_any     = 1'b0;
        odd_any      = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();
        expect_out("rst", ST_IDLE, 1, 0, 0, 0);
        chk("rst.ovf", 32'(overflow_err), 0);
        chk("rst.iter", 32'(iter_count), 0);

        reset = 1'b1;
        tick();
        expect_out("idle", ST_IDLE, 1, 0, 0, 0);

        // Load pass
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        expect_out("prep", ST_PREP, 0, 0, 0, 0);
        tick();
        expect_out("load0", ST_LOAD, 0, 1, 0, 0);
        tick();
        expect_out("wr0", ST_WR, 0, 0, 0, 0);
        tick();
        expect_out("load1", ST_LOAD, 0, 1, 0, 1);
        tick();
        expect_out("wr1", ST_WR, 0, 0, 0, 1);
        start_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("read0", ST_READ, 0, 0, 0, 0);
            chk("read0.iter", 32'(iter_count), 0);
        end
        start_valid = 1'b0;
        tick();
        expect_out("grow0", ST_GROW, 0, 0, 0, 0);

        // Context 0: quiet, no odd clusters
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("merge0", ST_MERGE, 0, 0, 0, 0);
            chk("merge0.iter", 32'(iter_count), 1);
        end
        tick();
        expect_out("peel0a", ST_PEEL, 0, 0, 0, 0);
        tick();
        expect_out("peel0b", ST_PEEL, 0, 0, 0, 0);
        tick();
        expect_out("result0", ST_PEEL, 0, 0, 1, 0);

        // Back-pressure on result
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("hold0", ST_PEEL, 0, 0, 1, 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        expect_out("saved0", ST_WR, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("read1", ST_READ, 0, 0, 0, 1);
            chk("read1.iter", 32'(iter_count), 0);
        end
        tick();
        expect_out("grow1", ST_GROW, 0, 0, 0, 1);

        // Context 1: busy at quiet count 2 restarts the quiet window
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("merge1", ST_MERGE, 0, 0, 0, 1);
            busy_any = (i == 4);
        end
        busy_any = 1'b0;
        tick();
        expect_out("peel1a", ST_PEEL, 0, 0, 0, 1);
        tick();
        tick();
        expect_out("result1", ST_PEEL, 0, 0, 1, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        expect_out("saved1", ST_WR, 0, 0, 0, 1);
        tick();
        expect_out("done", ST_IDLE, 1, 0, 0, 0);
        chk("done.ovf", 32'(overflow_err), 0);

        // Second job: odd clusters never resolve
        odd_any     = 1'b1;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        expect_out("prep2", ST_PREP, 0, 0, 0, 0);
        grows = 0;
        n     = 0;
        while (global_stage != ST_PEEL && n < 300) begin
            tick();
            n++;
            if (global_stage == ST_GROW)
                grows++;
        end
        chk("ovf.no_timeout", 32'(n < 300), 1);
        chk("ovf.grows", 32'(grows), 4);
        chk("ovf.flag", 32'(overflow_err), 1);
        chk("ovf.iter", 32'(iter_count), 4);
        tick();
        tick();
        expect_out("ovf.result", ST_PEEL, 0, 0, 1, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        expect_out("ovf.saved", ST_WR, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            tick();
        expect_out("ovf.read1", ST_READ, 0, 0, 0, 1);
        tick();
        expect_out("ovf.grow1", ST_GROW, 0, 0, 0, 1);
        chk("ovf.sticky", 32'(overflow_err), 1);
        tick();
        tick();
        expect_out("ovf.merge1", ST_MERGE, 0, 0, 0, 1);
        chk("ovf.merge1.iter", 32'(iter_count), 1);

        // Reset mid-decode
        reset = 1'b0;
        tick();
        expect_out("rst2", ST_IDLE, 1, 0, 0, 0);
        chk("rst2.ovf", 32'(overflow_err), 0);
        chk("rst2.iter", 32'(iter_count), 0);
        reset   = 1'b1;
        odd_any = 1'b0;
        tick();
        expect_out("rst2.idle", ST_IDLE, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
